// File: rtl/nrzi_pkg.sv
// nrzi_pkg
// Shared definitions for the NRZI receive/unstuff block.
//   nrzi_rx_state_t : packet framing states (IDLE, ARM, RUN)
//   *_DEF           : default values for the top-level parameters
//   runCntWidth()   : width needed for a ones-run counter that must reach STUFF_LEN
package nrzi_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2
  } nrzi_rx_state_t;

  localparam int   STUFF_LEN_DEF  = 6;
  localparam logic IDLE_LEVEL_DEF = 1'b1;
  localparam int   CNT_W_DEF      = 11;

  // The counter must hold the value STUFF_LEN itself, hence the +1.
  function automatic int runCntWidth(input int stuffLen);
    return $clog2(stuffLen + 1);
  endfunction

endpackage

// File: rtl/nrzi_run_counter.sv
// nrzi_run_counter
// Counts consecutive decoded 1s and flags when the run has reached STUFF_LEN.
//   clk_i      : clock, rising edge
//   rst_i      : synchronous active-high reset
//   clear_i    : force the run back to zero (has priority over inc_i)
//   inc_i      : extend the run by one
//   at_limit_o : run length equals STUFF_LEN, so the next bit is a stuff bit
module nrzi_run_counter
  import nrzi_pkg::*;
#(
  parameter int STUFF_LEN = STUFF_LEN_DEF,
  parameter int RUN_W     = runCntWidth(STUFF_LEN)
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic inc_i,
  output logic at_limit_o
);

  logic [RUN_W-1:0] run_q;

  // Run length register; clearing wins so a restart or a zero bit always
  // starts a fresh run even if the caller also raised inc_i.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      run_q <= '0;
    end else if (clear_i) begin
      run_q <= '0;
    end else if (inc_i) begin
      run_q <= run_q + RUN_W'(1);
    end
  end

  // Limit detect is taken straight off the register so it is stable for the
  // whole cycle in which the candidate stuff bit is examined.
  always_comb begin
    at_limit_o = (run_q == RUN_W'(STUFF_LEN));
  end

endmodule

// File: rtl/nrzi_unstuff_rx.sv
// nrzi_unstuff_rx
// NRZI decoder with bit unstuffing and stuff-error detection, one line bit per
// in_valid cycle, framed by start_rc/end_rc pulses. All outputs are registered.
//   clk, rst              : clock and synchronous active-high reset
//   s_in, in_valid        : raw line bit and its qualifier
//   start_rc, end_rc      : packet begin / end pulses (start wins if both)
//   unstuff_en            : 1 = drop stuff bits, 0 = pass every decoded bit
//   out_bit, out_valid    : decoded data bit and its qualifier
//   stuff_drop            : pulse, a stuff bit was removed
//   stuff_err             : sticky, a stuff violation was seen this packet
//   pkt_start, pkt_end    : packet framing pulses
//   bit_cnt               : saturating count of data bits emitted this packet
module nrzi_unstuff_rx
  import nrzi_pkg::*;
#(
  parameter int   STUFF_LEN  = STUFF_LEN_DEF,
  parameter logic IDLE_LEVEL = IDLE_LEVEL_DEF,
  parameter int   CNT_W      = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_in,
  input  logic             in_valid,
  input  logic             start_rc,
  input  logic             end_rc,
  input  logic             unstuff_en,
  output logic             out_bit,
  output logic             out_valid,
  output logic             stuff_drop,
  output logic             stuff_err,
  output logic             pkt_start,
  output logic             pkt_end,
  output logic [CNT_W-1:0] bit_cnt
);

  localparam int RUN_W = runCntWidth(STUFF_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  nrzi_rx_state_t state_q, state_d;

  logic             prev_q, prev_d;
  logic             out_bit_q, out_bit_d;
  logic             out_valid_q, out_valid_d;
  logic             stuff_drop_q, stuff_drop_d;
  logic             stuff_err_q, stuff_err_d;
  logic             pkt_start_q, pkt_start_d;
  logic             pkt_end_q, pkt_end_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;

  logic inPacket;
  logic accept;
  logic decBit;
  logic runClear;
  logic runInc;
  logic atLimit;

  nrzi_run_counter #(
    .STUFF_LEN(STUFF_LEN),
    .RUN_W    (RUN_W)
  ) u_run (
    .clk_i     (clk),
    .rst_i     (rst),
    .clear_i   (runClear),
    .inc_i     (runInc),
    .at_limit_o(atLimit)
  );

  // A bit is only taken inside a packet, and a bit arriving together with a
  // start pulse belongs to the abandoned packet so it is thrown away.
  always_comb begin
    inPacket = (state_q == ARM) || (state_q == RUN);
    accept   = in_valid && inPacket && !start_rc;
    decBit   = ~(s_in ^ prev_q);
  end

  // Framing state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; start_rc is checked first everywhere so it beats end_rc.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start_rc) state_d = ARM;
      end
      ARM: begin
        if (start_rc)    state_d = ARM;
        else if (end_rc) state_d = IDLE;
        else             state_d = RUN;
      end
      RUN: begin
        if (start_rc)    state_d = ARM;
        else if (end_rc) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output and datapath next values. A start pulse re-arms the NRZI reference
  // and clears the per-packet status; otherwise an accepted bit is decoded and
  // either emitted or, at the run limit with unstuffing on, swallowed. In
  // bypass the run counter holds at the limit instead of wrapping, so it keeps
  // describing the data without ever forcing a drop.
  always_comb begin
    prev_d       = prev_q;
    out_bit_d    = 1'b0;
    out_valid_d  = 1'b0;
    stuff_drop_d = 1'b0;
    stuff_err_d  = stuff_err_q;
    bit_cnt_d    = bit_cnt_q;
    pkt_start_d  = start_rc;
    pkt_end_d    = inPacket && end_rc && !start_rc;
    runClear     = 1'b0;
    runInc       = 1'b0;
    if (start_rc) begin
      prev_d      = IDLE_LEVEL;
      runClear    = 1'b1;
      bit_cnt_d   = '0;
      stuff_err_d = 1'b0;
    end else if (accept) begin
      prev_d = s_in;
      if (unstuff_en && atLimit) begin
        runClear = 1'b1;
        if (decBit) begin
          stuff_err_d = 1'b1;
        end else begin
          stuff_drop_d = 1'b1;
        end
      end else begin
        out_valid_d = 1'b1;
        out_bit_d   = decBit;
        if (bit_cnt_q != CNT_MAX) begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
        if (decBit) begin
          runInc = !atLimit;
        end else begin
          runClear = 1'b1;
        end
      end
    end
  end

  // Output and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q       <= IDLE_LEVEL;
      out_bit_q    <= 1'b0;
      out_valid_q  <= 1'b0;
      stuff_drop_q <= 1'b0;
      stuff_err_q  <= 1'b0;
      pkt_start_q  <= 1'b0;
      pkt_end_q    <= 1'b0;
      bit_cnt_q    <= '0;
    end else begin
      prev_q       <= prev_d;
      out_bit_q    <= out_bit_d;
      out_valid_q  <= out_valid_d;
      stuff_drop_q <= stuff_drop_d;
      stuff_err_q  <= stuff_err_d;
      pkt_start_q  <= pkt_start_d;
      pkt_end_q    <= pkt_end_d;
      bit_cnt_q    <= bit_cnt_d;
    end
  end

  assign out_bit    = out_bit_q;
  assign out_valid  = out_valid_q;
  assign stuff_drop = stuff_drop_q;
  assign stuff_err  = stuff_err_q;
  assign pkt_start  = pkt_start_q;
  assign pkt_end    = pkt_end_q;
  assign bit_cnt    = bit_cnt_q;

endmodule

// File: tb/tb_nrzi_unstuff_rx.sv
// tb_nrzi_unstuff_rx
// Directed bench for nrzi_unstuff_rx with default parameters (STUFF_LEN = 6,
// IDLE_LEVEL = 1, CNT_W = 11). Each record holds the inputs for one cycle and
// the outputs expected right after the following rising edge.
module tb_nrzi_unstuff_rx;

  typedef struct {
    logic        rs;
    logic        st;
    logic        en;
    logic        va;
    logic        s;
    logic        un;
    logic        eValid;
    logic        eBit;
    logic        eDrop;
    logic        eErr;
    logic        eStart;
    logic        eEnd;
    logic [10:0] eCnt;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        sIn;
  logic        inValid;
  logic        startRc;
  logic        endRc;
  logic        unstuffEn;
  logic        outBit;
  logic        outValid;
  logic        stuffDrop;
  logic        stuffErr;
  logic        pktStart;
  logic        pktEnd;
  logic [10:0] bitCnt;

  int   total;
  int   bad;
  vec_t vecs[$];

  nrzi_unstuff_rx dut (
    .clk       (clk),
    .rst       (rst),
    .s_in      (sIn),
    .in_valid  (inValid),
    .start_rc  (startRc),
    .end_rc    (endRc),
    .unstuff_en(unstuffEn),
    .out_bit   (outBit),
    .out_valid (outValid),
    .stuff_drop(stuffDrop),
    .stuff_err (stuffErr),
    .pkt_start (pktStart),
    .pkt_end   (pktEnd),
    .bit_cnt   (bitCnt)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Builds one record from flat arguments.
  function automatic vec_t mk(input logic rs, st, en, va, s, un,
                              input logic ev, eb, ed, ee, es, ene, input int cnt);
    vec_t v;
    v.rs = rs; v.st = st; v.en = en; v.va = va; v.s = s; v.un = un;
    v.eValid = ev; v.eBit = eb; v.eDrop = ed; v.eErr = ee;
    v.eStart = es; v.eEnd = ene; v.eCnt = 11'(cnt);
    return v;
  endfunction

  // Appends a normal (non-reset) table row.
  task automatic addVec(input logic st, en, va, s, un,
                        input logic ev, eb, ed, ee, es, ene, input int cnt);
    vecs.push_back(mk(1'b0, st, en, va, s, un, ev, eb, ed, ee, es, ene, cnt));
  endtask

  // Drives one cycle of inputs.
  task automatic applyStimulus(input vec_t v);
    rst       = v.rs;
    startRc   = v.st;
    endRc     = v.en;
    inValid   = v.va;
    sIn       = v.s;
    unstuffEn = v.un;
  endtask

  // Compares the registered outputs against the record's expectations.
  task automatic checkOutput(input vec_t v, input string tag);
    logic [4:0] gotFlags;
    logic [4:0] expFlags;
    gotFlags = {outValid, stuffDrop, stuffErr, pktStart, pktEnd};
    expFlags = {v.eValid, v.eDrop, v.eErr, v.eStart, v.eEnd};
    total++;
    if (gotFlags !== expFlags) begin
      bad++;
      $display("[TB] FAIL %s flags(valid,drop,err,start,end) got=%b want=%b",
               tag, gotFlags, expFlags);
    end
    if (v.eValid) begin
      total++;
      if (outBit !== v.eBit) begin
        bad++;
        $display("[TB] FAIL %s out_bit got=%b want=%b", tag, outBit, v.eBit);
      end
    end
    total++;
    if (bitCnt !== v.eCnt) begin
      bad++;
      $display("[TB] FAIL %s bit_cnt got=%0d want=%0d", tag, bitCnt, v.eCnt);
    end
  endtask

  // One full cycle: drive, clock, sample 1 time unit after the edge.
  task automatic step(input vec_t v, input string tag);
    applyStimulus(v);
    @(posedge clk);
    #1;
    checkOutput(v, tag);
  endtask

  initial begin
    total = 0;
    bad   = 0;

    // Plain decode: line 1,0,0,1 -> data 1,0,1,0, then an ignored idle bit.
    addVec(1,0,0,0,1, 0,0,0,0,1,0, 0);
    addVec(0,0,1,1,1, 1,1,0,0,0,0, 1);
    addVec(0,0,1,0,1, 1,0,0,0,0,0, 2);
    addVec(0,0,1,0,1, 1,1,0,0,0,0, 3);
    addVec(0,0,1,1,1, 1,0,0,0,0,0, 4);
    addVec(0,1,0,0,1, 0,0,0,0,0,1, 4);
    addVec(0,0,1,0,1, 0,0,0,0,0,0, 4);

    // Stuff removal: six 1s, stuff 0 dropped, final line 0 decodes to 1.
    addVec(1,0,0,0,1, 0,0,0,0,1,0, 0);
    for (int k = 1; k <= 6; k++) addVec(0,0,1,1,1, 1,1,0,0,0,0, k);
    addVec(0,0,1,0,1, 0,0,1,0,0,0, 6);
    addVec(0,0,1,0,1, 1,1,0,0,0,0, 7);
    addVec(0,1,0,0,1, 0,0,0,0,0,1, 7);

    // Stuff error: seventh 1 flags error, held through IDLE, cleared by start.
    addVec(1,0,0,0,1, 0,0,0,0,1,0, 0);
    for (int k = 1; k <= 6; k++) addVec(0,0,1,1,1, 1,1,0,0,0,0, k);
    addVec(0,0,1,1,1, 0,0,0,1,0,0, 6);
    addVec(0,1,0,0,1, 0,0,0,1,0,1, 6);
    addVec(0,0,0,0,1, 0,0,0,1,0,0, 6);
    addVec(1,0,0,0,1, 0,0,0,0,1,0, 0);
    addVec(0,1,0,0,1, 0,0,0,0,0,1, 0);

    // Bypass: same line stream, all eight bits come out.
    addVec(1,0,0,0,0, 0,0,0,0,1,0, 0);
    for (int k = 1; k <= 6; k++) addVec(0,0,1,1,0, 1,1,0,0,0,0, k);
    addVec(0,0,1,0,0, 1,0,0,0,0,0, 7);
    addVec(0,0,1,0,0, 1,1,0,0,0,0, 8);
    addVec(0,1,0,0,0, 0,0,0,0,0,1, 8);

    // Restart mid-run clears run counter and NRZI reference; start beats end.
    addVec(1,0,0,0,1, 0,0,0,0,1,0, 0);
    for (int k = 1; k <= 5; k++) addVec(0,0,1,1,1, 1,1,0,0,0,0, k);
    addVec(1,0,1,0,1, 0,0,0,0,1,0, 0);
    for (int k = 1; k <= 6; k++) addVec(0,0,1,1,1, 1,1,0,0,0,0, k);
    addVec(0,0,1,0,1, 0,0,1,0,0,0, 6);
    addVec(1,1,0,0,1, 0,0,0,0,1,0, 0);
    addVec(0,1,0,0,1, 0,0,0,0,0,1, 0);

    // Sparse valid every third cycle, last bit together with end_rc.
    addVec(1,0,0,0,1, 0,0,0,0,1,0, 0);
    addVec(0,0,1,1,1, 1,1,0,0,0,0, 1);
    addVec(0,0,0,0,1, 0,0,0,0,0,0, 1);
    addVec(0,0,0,0,1, 0,0,0,0,0,0, 1);
    addVec(0,0,1,0,1, 1,0,0,0,0,0, 2);
    addVec(0,0,0,1,1, 0,0,0,0,0,0, 2);
    addVec(0,0,0,1,1, 0,0,0,0,0,0, 2);
    addVec(0,0,1,0,1, 1,1,0,0,0,0, 3);
    addVec(0,0,0,1,1, 0,0,0,0,0,0, 3);
    addVec(0,0,0,1,1, 0,0,0,0,0,0, 3);
    addVec(0,1,1,1,1, 1,0,0,0,0,1, 4);

    $display("[TB] reset check");
    step(mk(1,0,0,0,0,1, 0,0,0,0,0,0, 0), "reset0");
    step(mk(1,0,0,0,0,1, 0,0,0,0,0,0, 0), "reset1");

    $display("[TB] table of %0d vectors", vecs.size());
    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i], $sformatf("tbl%0d", i));
    end

    // Reset mid-packet with stuff_err already set: everything back to zero,
    // idle bits ignored, and the next packet decodes from IDLE_LEVEL.
    $display("[TB] reset mid-packet");
    step(mk(0,1,0,0,0,1, 0,0,0,0,1,0, 0), "rstSeqStart");
    for (int k = 1; k <= 6; k++) begin
      step(mk(0,0,0,1,1,1, 1,1,0,0,0,0, k), $sformatf("rstSeqBit%0d", k));
    end
    step(mk(0,0,0,1,1,1, 0,0,0,1,0,0, 6), "rstSeqErr");
    step(mk(1,0,0,1,0,1, 0,0,0,0,0,0, 0), "rstSeqAssert");
    step(mk(0,0,0,1,1,1, 0,0,0,0,0,0, 0), "rstSeqIgn0");
    step(mk(0,0,0,1,0,1, 0,0,0,0,0,0, 0), "rstSeqIgn1");
    step(mk(0,1,0,0,0,1, 0,0,0,0,1,0, 0), "rstSeqRestart");
    step(mk(0,0,0,1,0,1, 1,0,0,0,0,0, 1), "rstSeqFirst");
    step(mk(0,0,1,0,0,1, 0,0,0,0,0,1, 1), "rstSeqEnd");

    // bit_cnt saturation: alternating line levels decode to all zeros, so no
    // stuffing occurs and every bit is counted until 2047.
    $display("[TB] bit_cnt saturation");
    step(mk(0,1,0,0,0,1, 0,0,0,0,1,0, 0), "satStart");
    for (int i = 0; i < 2050; i++) begin
      logic s;
      int   expCnt;
      s      = (i % 2 == 0) ? 1'b0 : 1'b1;
      expCnt = (i + 1 > 2047) ? 2047 : i + 1;
      step(mk(0,0,0,1,s,1, 1,0,0,0,0,0, expCnt), $sformatf("sat%0d", i));
    end
    step(mk(0,0,1,0,0,1, 0,0,0,0,0,1, 2047), "satEnd");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
